combo_detector: RTL

- Consumes single-cycle pulses from the per-button debouncers and recognises special-move sequences for one player.
- Sequences are direction presses followed by punch/kick, with each press arriving within a time window of the previous one.
- Emits a 3-bit move code to the fighter state logic over a valid/ack handshake.

---
 rtl/combo_detector_if.sv | 10 +
 rtl/combo_detector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/combo_detector_if.sv
// rtl/combo_detector_if.sv - move handshake bundle between combo_detector and fighter logic
interface combo_detector_if;
  logic       move_valid;
  logic [2:0] move_code;
  logic       move_drop;
  logic       move_ack;

  modport master (output move_valid, output move_code, output move_drop, input move_ack);
  modport slave  (input move_valid, input move_code, input move_drop, output move_ack);
endinterface

// File: rtl/combo_detector.sv
// rtl/combo_detector.sv - special-move sequence recogniser with valid/ack move output
// Optional macro COMBO_SUPER_EN: 4-deep history and super move (code 6).
module combo_detector #(
  parameter int unsigned WINDOW = 15000000,
  parameter int unsigned CNT_W  = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_punch,
  input  logic             btn_kick,
  input  logic             facing_right,
  combo_detector_if.master mif
);

`ifdef COMBO_SUPER_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 3;
`endif

  localparam logic [2:0] TOK_NONE = 3'd0;
  localparam logic [2:0] TOK_DOWN = 3'd1;
  localparam logic [2:0] TOK_FWD  = 3'd2;
  localparam logic [2:0] TOK_BACK = 3'd3;
  localparam logic [2:0] TOK_UP   = 3'd4;

  localparam logic [8:0] UPPERCUT_SEQ  = {TOK_FWD, TOK_DOWN, TOK_FWD};
  localparam logic [5:0] FIREBALL_SEQ  = {TOK_DOWN, TOK_FWD};
  localparam logic [5:0] HURRICANE_SEQ = {TOK_DOWN, TOK_BACK};
`ifdef COMBO_SUPER_EN
  localparam logic [11:0] SUPER_SEQ    = {TOK_DOWN, TOK_FWD, TOK_DOWN, TOK_FWD};
`endif

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  logic [DEPTH-1:0][2:0] hist_q, hist_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  drop_q, drop_d;
  logic [2:0]            code_q, code_d;

  logic       fwd_btn, back_btn, is_move;
  logic [2:0] dir_tok, new_code;

  assign fwd_btn  = facing_right ? btn_right : btn_left;
  assign back_btn = facing_right ? btn_left  : btn_right;
  assign is_move  = btn_punch | btn_kick;

  always_comb begin
    dir_tok = TOK_NONE;
    if (btn_down)      dir_tok = TOK_DOWN;
    else if (fwd_btn)  dir_tok = TOK_FWD;
    else if (back_btn) dir_tok = TOK_BACK;
    else if (btn_up)   dir_tok = TOK_UP;
  end

  // Matches use the history as registered, i.e. before this cycle's token.
  always_comb begin
    new_code = 3'd0;
    if (btn_punch) begin
      if (hist_q[2:0] == UPPERCUT_SEQ)      new_code = 3'd2;
      else if (hist_q[1:0] == FIREBALL_SEQ) new_code = 3'd1;
      else                                  new_code = 3'd4;
`ifdef COMBO_SUPER_EN
      if (hist_q == SUPER_SEQ)              new_code = 3'd6;
`endif
    end else if (btn_kick) begin
      if (hist_q[1:0] == HURRICANE_SEQ)     new_code = 3'd3;
      else                                  new_code = 3'd5;
    end
  end

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (is_move) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (dir_tok != TOK_NONE) begin
      hist_d = {hist_q[DEPTH-2:0], dir_tok};
      cnt_d  = '0;
    end else if (cnt_q != WIN) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == WIN - 1'b1) hist_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_move) begin
          valid_d = 1'b1;
          code_d  = new_code;
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (mif.move_ack) begin
          if (is_move) begin
            code_d = new_code;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end else if (is_move) begin
          drop_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      code_q  <= code_d;
    end
  end

  assign mif.move_valid = valid_q;
  assign mif.move_code  = code_q;
  assign mif.move_drop  = drop_q;

endmodule
